sdram_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single SDRAM slave port (24-bit byte address, 16-bit data, single-cycle `iACK` handshake) between two bus masters, e.g. the frame-capture write master and the processing read master. Round-robin grant with a per-grant burst limit prevents either master from starving the other. Sits between the masters and the SDRAM controller slave port; masters see a private port with the same protocol they would see on the slave.

---
 rtl/sdram_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 19 +
 rtl/sdram_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_bus_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-master SDRAM bus arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

    localparam int unsigned AddrWDefault = 24;
    localparam int unsigned DataWDefault = 16;
    localparam int unsigned BeW          = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: favours the requester that was not served last.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,   // 1: master 1 was served last
    output logic valid_o,
    output logic pick_o    // 1: master 1 wins
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            pick_o = ~last_i;
        end else begin
            pick_o = req1_i;
        end
    end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Round-robin, burst-limited arbiter sharing one SDRAM slave port between two masters.
// Optional grant watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_bus_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = AddrWDefault,
    parameter int unsigned DATA_W    = DataWDefault,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iM0_Read,
    input  logic              iM0_Write,
    input  logic [ADDR_W-1:0] iM0_Addr,
    input  logic [BeW-1:0]    iM0_BE,
    input  logic [DATA_W-1:0] iM0_Data,
    output logic              oM0_ACK,
    output logic [DATA_W-1:0] oM0_Data,
    input  logic              iM1_Read,
    input  logic              iM1_Write,
    input  logic [ADDR_W-1:0] iM1_Addr,
    input  logic [BeW-1:0]    iM1_BE,
    input  logic [DATA_W-1:0] iM1_Data,
    output logic              oM1_ACK,
    output logic [DATA_W-1:0] oM1_Data,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oRead,
    output logic              oWrite,
    output logic [BeW-1:0]    oBE,
    output logic [DATA_W-1:0] oData,
    input  logic              iACK,
    input  logic [DATA_W-1:0] iData,
    output logic [1:0]        oGrant,
    output logic              oTimeout
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be in 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..255");
    end

    arb_state_e state_q, state_d;
    logic       last_q;
    logic [7:0] cnt_q;
    logic       req0, req1, granted, own_req, last_sel, valid, pick, enter, release_g, tmo_hit;

    assign req0    = iM0_Read | iM0_Write;
    assign req1    = iM1_Read | iM1_Write;
    assign granted = (state_q == StGnt0) || (state_q == StGnt1);
    assign own_req = (state_q == StGnt0) ? req0 : req1;

    // In a grant state the owner counts as "last served" so the other side wins on release.
    assign last_sel = (state_q == StGnt0) ? 1'b0 : (state_q == StGnt1) ? 1'b1 : last_q;

    rr_pick2 u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (last_sel),
        .valid_o(valid),
        .pick_o (pick)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [7:0] wdog_q;
    logic       tmo_q;
    assign tmo_hit  = granted && own_req && !iACK && (wdog_q == 8'(TIMEOUT - 1));
    assign oTimeout = tmo_q;
`else
    assign tmo_hit  = 1'b0;
    assign oTimeout = 1'b0;
`endif

    assign release_g = granted &&
                       (!own_req || (iACK && (cnt_q == 8'(MAX_BURST - 1))) || tmo_hit);

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        if ((state_q == StIdle || release_g) && valid) begin
            state_d = pick ? StGnt1 : StGnt0;
            enter   = 1'b1;
        end else if (release_g || !granted) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wdog_q  <= 8'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (enter) begin
                last_q <= pick;
            end
            if (enter || state_d == StIdle) begin
                cnt_q <= 8'd0;
            end else if (granted && iACK) begin
                cnt_q <= cnt_q + 8'd1;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            if (enter || state_d == StIdle || iACK) begin
                wdog_q <= 8'd0;
            end else if (granted && own_req) begin
                wdog_q <= wdog_q + 8'd1;
            end
            tmo_q <= tmo_hit;
`endif
        end
    end

    always_comb begin
        oAddr    = '0;
        oRead    = 1'b0;
        oWrite   = 1'b0;
        oBE      = '0;
        oData    = '0;
        oM0_ACK  = 1'b0;
        oM1_ACK  = 1'b0;
        oM0_Data = '0;
        oM1_Data = '0;
        oGrant   = 2'b00;
        case (state_q)
            StGnt0: begin
                oAddr    = iM0_Addr;
                oRead    = iM0_Read;
                oWrite   = iM0_Write & ~iM0_Read;
                oBE      = iM0_BE;
                oData    = iM0_Data;
                oM0_ACK  = iACK;
                oM0_Data = iData;
                oM1_Data = iData;
                oGrant   = 2'b01;
            end
            StGnt1: begin
                oAddr    = iM1_Addr;
                oRead    = iM1_Read;
                oWrite   = iM1_Write & ~iM1_Read;
                oBE      = iM1_BE;
                oData    = iM1_Data;
                oM1_ACK  = iACK;
                oM0_Data = iData;
                oM1_Data = iData;
                oGrant   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed self-checking bench for sdram_bus_arbiter (MAX_BURST=8, TIMEOUT=16).
module tb_sdram_bus_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iM0_Read, iM0_Write, iM1_Read, iM1_Write;
    logic [23:0] iM0_Addr, iM1_Addr;
    logic [1:0]  iM0_BE, iM1_BE;
    logic [15:0] iM0_Data, iM1_Data;
    logic        oM0_ACK, oM1_ACK;
    logic [15:0] oM0_Data, oM1_Data;
    logic [23:0] oAddr;
    logic        oRead, oWrite;
    logic [1:0]  oBE;
    logic [15:0] oData;
    logic        iACK;
    logic [15:0] iData;
    logic [1:0]  oGrant;
    logic        oTimeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 iCLK = ~iCLK;

    sdram_bus_arbiter #(
        .ADDR_W   (24),
        .DATA_W   (16),
        .MAX_BURST(8),
        .TIMEOUT  (16)
    ) u_dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iM0_Read (iM0_Read),
        .iM0_Write(iM0_Write),
        .iM0_Addr (iM0_Addr),
        .iM0_BE   (iM0_BE),
        .iM0_Data (iM0_Data),
        .oM0_ACK  (oM0_ACK),
        .oM0_Data (oM0_Data),
        .iM1_Read (iM1_Read),
        .iM1_Write(iM1_Write),
        .iM1_Addr (iM1_Addr),
        .iM1_BE   (iM1_BE),
        .iM1_Data (iM1_Data),
        .oM1_ACK  (oM1_ACK),
        .oM1_Data (oM1_Data),
        .oAddr    (oAddr),
        .oRead    (oRead),
        .oWrite   (oWrite),
        .oBE      (oBE),
        .oData    (oData),
        .iACK     (iACK),
        .iData    (iData),
        .oGrant   (oGrant),
        .oTimeout (oTimeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive point: just after the active edge.
    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_inputs();
        iM0_Read = 0; iM0_Write = 0; iM0_Addr = '0; iM0_BE = '0; iM0_Data = '0;
        iM1_Read = 0; iM1_Write = 0; iM1_Addr = '0; iM1_BE = '0; iM1_Data = '0;
        iACK = 0; iData = '0;
    endtask

    task automatic do_reset();
        iRST = 1'b0;
        cyc();
        cyc();
        iRST = 1'b1;
    endtask

    initial begin
        clear_inputs();
        iRST = 1'b0;
        cyc();
        @(negedge iCLK);
        chk("rst_grant", 32'(oGrant), 32'h0);
        chk("rst_timeout", 32'(oTimeout), 32'h0);
        cyc();
        iRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            chk("idle_grant", 32'(oGrant), 32'h0);
            chk("idle_cmd", {6'd0, oRead, oWrite, oAddr}, 32'h0);
        end

        // Single master write with ack in its third request cycle.
        cyc();
        iM0_Write = 1; iM0_Addr = 24'h800000; iM0_Data = 16'h1111; iM0_BE = 2'b11;
        @(negedge iCLK);
        chk("m0_not_yet", 32'(oGrant), 32'h0);
        cyc();
        @(negedge iCLK);
        chk("m0_grant", 32'(oGrant), 32'h1);
        chk("m0_cmd", {6'd0, oRead, oWrite, oAddr}, {6'd0, 2'b01, 24'h800000});
        chk("m0_wdata", {14'd0, oBE, oData}, {14'd0, 2'b11, 16'h1111});
        chk("m0_noack", 32'(oM0_ACK), 32'h0);
        cyc();
        iACK = 1;
        @(negedge iCLK);
        chk("m0_ack", {30'd0, oM1_ACK, oM0_ACK}, 32'h1);
        cyc();
        iACK = 0; iM0_Write = 0;
        @(negedge iCLK);
        chk("m0_drop_grant", 32'(oGrant), 32'h1);
        chk("m0_drop_wr", 32'(oWrite), 32'h0);
        cyc();
        @(negedge iCLK);
        chk("m0_idle", 32'(oGrant), 32'h0);

        // Simultaneous requests from reset; M1 drives read and write together.
        do_reset();
        iM0_Write = 1; iM0_Addr = 24'h000100; iM0_Data = 16'h2222;
        iM1_Read = 1; iM1_Write = 1; iM1_Addr = 24'h000200;
        @(negedge iCLK);
        chk("sim_idle", 32'(oGrant), 32'h0);
        cyc();
        @(negedge iCLK);
        chk("sim_gnt0", 32'(oGrant), 32'h1);
        chk("sim_addr0", 32'(oAddr), 32'h100);
        cyc();
        iM0_Write = 0;
        @(negedge iCLK);
        chk("sim_drop0", 32'(oGrant), 32'h1);
        cyc();
        @(negedge iCLK);
        chk("sim_gnt1", 32'(oGrant), 32'h2);
        chk("mask_cmd", {6'd0, oRead, oWrite, oAddr}, {6'd0, 2'b10, 24'h000200});
        cyc();
        iACK = 1; iData = 16'hBEEF;
        @(negedge iCLK);
        chk("m1_ack", {30'd0, oM1_ACK, oM0_ACK}, 32'h2);
        chk("m1_rdata", 32'(oM1_Data), 32'hBEEF);
        cyc();
        clear_inputs();
        cyc();
        @(negedge iCLK);
        chk("sim_idle_end", 32'(oGrant), 32'h0);

        // Burst limit: both request, slave acks every cycle, pointer says M1 served last.
        cyc();
        iM0_Write = 1; iM1_Read = 1; iACK = 1;
        @(negedge iCLK);
        chk("burst_idle", {29'd0, oGrant, oM0_ACK}, 32'h0);
        for (int i = 0; i < 24; i++) begin
            @(negedge iCLK);
            chk("burst_grant", 32'(oGrant), ((i / 8) % 2 == 0) ? 32'h1 : 32'h2);
            chk("burst_ack0", 32'(oM0_ACK), ((i / 8) % 2 == 0) ? 32'h1 : 32'h0);
        end
        cyc();
        clear_inputs();
        cyc();
        @(negedge iCLK);
        chk("burst_idle_end", 32'(oGrant), 32'h0);

        // Watchdog: M0 granted, no acks, M1 waiting.
        do_reset();
        iM0_Write = 1; iM1_Read = 1;
        @(negedge iCLK);
        chk("wd_idle", 32'(oGrant), 32'h0);
`ifdef SDRAM_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge iCLK);
            chk("wd_hold", {30'd0, oGrant}, 32'h1);
            chk("wd_quiet", 32'(oTimeout), 32'h0);
        end
        @(negedge iCLK);
        chk("wd_switch", 32'(oGrant), 32'h2);
        chk("wd_pulse", 32'(oTimeout), 32'h1);
        @(negedge iCLK);
        chk("wd_pulse_end", 32'(oTimeout), 32'h0);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            chk("nowd_hold", 32'(oGrant), 32'h1);
            chk("nowd_tmo", 32'(oTimeout), 32'h0);
        end
`endif
        clear_inputs();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
